// File: rtl/io_ctrl_if.sv
// io_ctrl bus bundle: CPU byte bus, read return, UART TX/RX handshakes.
interface io_ctrl_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  io_dout;
  logic        io_sel;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_finish;

  modport master (
    output mem_a, mem_dout, mem_wr,
    output tx_ready, rx_data, rx_valid,
    input  io_dout, io_sel, io_buffer_full,
    input  tx_data, tx_valid, rx_ready,
    input  program_finish
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr,
    input  tx_ready, rx_data, rx_valid,
    output io_dout, io_sel, io_buffer_full,
    output tx_data, tx_valid, rx_ready,
    output program_finish
  );
endinterface

// File: rtl/io_ctrl.sv
// Memory-mapped I/O: UART TX FIFO, RX holding byte, cycle counter, stop port.
// Reads return one cycle after the request to line up with RAM latency.
module io_ctrl #(
  parameter int TX_DEPTH = 8,
  parameter int TX_AW    = 3
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  io_ctrl_if.slave  bus
);
  localparam logic [17:0] A_TX   = 18'h30000;
  localparam logic [17:0] A_STOP = 18'h30004;
  localparam logic [17:0] A_C1   = 18'h30005;
  localparam logic [17:0] A_C2   = 18'h30006;
  localparam logic [17:0] A_C3   = 18'h30007;
  localparam logic [TX_AW:0] FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [TX_AW:0] ALMOST   = (TX_AW+1)'(TX_DEPTH - 2);

  logic [7:0]     fifo [TX_DEPTH];
  logic [TX_AW-1:0] rptr, wptr;
  logic [TX_AW:0] count, cnt_nxt;
  logic [31:0]    cyc;
  logic [23:0]    snap;
  logic [7:0]     rx_buf;
  logic           rx_full;
  logic           stop_pending;
  logic [7:0]     dout_q;
  logic           sel_q, full_q, fin_q;

  logic [17:0] a;
  logic        acc, rd, wr, wr_tx, wr_stop;
  logic        push, pop, rx_rd, cap;
  logic [7:0]  push_byte, rd_data;
  logic        unused;

  assign a      = bus.mem_a[17:0];
  assign unused = ^bus.mem_a[31:18];

  always_comb begin
    acc       = rdy_in && (a[17:16] == 2'b11);
    rd        = acc && !bus.mem_wr;
    wr        = acc && bus.mem_wr;
    wr_tx     = wr && (a == A_TX) && (bus.mem_dout != 8'h00);
    wr_stop   = wr && (a == A_STOP);
    push      = (wr_tx || wr_stop) && (count != FULL_CNT);
    pop       = (count != '0) && bus.tx_ready;
    push_byte = wr_stop ? 8'h00 : bus.mem_dout;
    cnt_nxt   = count + (TX_AW+1)'(push) - (TX_AW+1)'(pop);
    rx_rd     = rd && (a == A_TX);
    cap       = bus.rx_valid && !rx_full;
  end

  always_comb begin
    rd_data = 8'h00;
    unique case (1'b1)
      (a == A_TX):   rd_data = rx_full ? rx_buf : 8'h00;
      (a == A_STOP): rd_data = cyc[7:0];
      (a == A_C1):   rd_data = snap[7:0];
      (a == A_C2):   rd_data = snap[15:8];
      (a == A_C3):   rd_data = snap[23:16];
      default:       rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < TX_DEPTH; i++) fifo[i] <= 8'h00;
      rptr         <= '0;
      wptr         <= '0;
      count        <= '0;
      full_q       <= 1'b0;
      stop_pending <= 1'b0;
      fin_q        <= 1'b0;
    end else begin
      if (push) begin
        fifo[wptr] <= push_byte;
        wptr       <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count  <= cnt_nxt;
      full_q <= cnt_nxt >= ALMOST;
      // Finish only once the stop marker itself has left the FIFO
      if (stop_pending && pop && cnt_nxt == '0) fin_q <= 1'b1;
      if (wr_stop) stop_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cyc     <= '0;
      snap    <= '0;
      rx_buf  <= 8'h00;
      rx_full <= 1'b0;
      dout_q  <= 8'h00;
      sel_q   <= 1'b0;
    end else begin
      if (rdy_in) cyc <= cyc + 32'd1;
      if (rd && a == A_STOP) snap <= cyc[31:8];
      if (cap) begin
        rx_buf  <= bus.rx_data;
        rx_full <= 1'b1;
      end else if (rx_rd) begin
        rx_full <= 1'b0;
      end
      sel_q  <= rd;
      dout_q <= rd ? rd_data : 8'h00;
    end
  end

  assign bus.io_dout        = dout_q;
  assign bus.io_sel         = sel_q;
  assign bus.io_buffer_full = full_q;
  assign bus.tx_data        = fifo[rptr];
  assign bus.tx_valid       = count != '0;
  assign bus.rx_ready       = !rx_full;
  assign bus.program_finish = fin_q;
endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl against a queue-based reference model.
module tb_io_ctrl;
  localparam int DEPTH = 8;

  logic clk, rst_n, rdy;
  io_ctrl_if bus();

  io_ctrl #(.TX_DEPTH(DEPTH), .TX_AW(3)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned q[$];
  bit           stop_pend, fin, rx_has;
  byte unsigned rx_b;
  int unsigned  cyc_m, snap_m;
  logic [7:0]   exp_dout;
  bit           exp_sel;

  task automatic model_clear();
    q.delete();
    stop_pend = 0; fin = 0; rx_has = 0; rx_b = 0;
    cyc_m = 0; snap_m = 0; exp_dout = 0; exp_sel = 0;
  endtask

  task automatic idle();
    bus.mem_a = 32'h0; bus.mem_dout = 8'h0; bus.mem_wr = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h0;
  endtask

  task automatic set_wr(input logic [17:0] ad, input logic [7:0] d);
    bus.mem_a = {14'h0, ad}; bus.mem_dout = d; bus.mem_wr = 1'b1;
  endtask

  task automatic set_rd(input logic [17:0] ad);
    bus.mem_a = {14'h0, ad}; bus.mem_dout = 8'h0; bus.mem_wr = 1'b0;
  endtask

  // Apply one clock edge to the model and the DUT with the current inputs.
  task automatic step();
    logic [17:0] a;
    bit acc, rd, wr, popq, pushq;
    byte unsigned v, d;
    a = bus.mem_a[17:0];
    acc = rdy && a[17:16] == 2'b11;
    rd = acc && !bus.mem_wr;
    wr = acc && bus.mem_wr;
    d = 0;
    if (rd) begin
      if (a == 18'h30000) d = rx_has ? rx_b : 8'h00;
      else if (a == 18'h30004) d = cyc_m[7:0];
      else if (a == 18'h30005) d = snap_m[15:8];
      else if (a == 18'h30006) d = snap_m[23:16];
      else if (a == 18'h30007) d = snap_m[31:24];
    end
    exp_sel = rd;
    exp_dout = d;
    if (rd && a == 18'h30004) snap_m = cyc_m;
    popq = q.size() > 0 && bus.tx_ready;
    pushq = 0; v = 0;
    if (wr && a == 18'h30000 && bus.mem_dout != 0) begin
      pushq = 1; v = bus.mem_dout;
    end
    if (wr && a == 18'h30004) begin pushq = 1; v = 0; end
    if (pushq && q.size() >= DEPTH) pushq = 0;
    if (popq) void'(q.pop_front());
    if (pushq) q.push_back(v);
    if (popq && stop_pend && q.size() == 0) fin = 1;
    if (wr && a == 18'h30004) stop_pend = 1;
    if (bus.rx_valid && !rx_has) begin
      rx_has = 1; rx_b = bus.rx_data;
    end else if (rd && a == 18'h30000) begin
      rx_has = 0;
    end
    if (rdy) cyc_m++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); bus.tx_ready = 1'b0; rdy = 1'b1;
    rst_n = 1'b0;
    model_clear();
    #12;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.io_dout !== 8'h00) begin n_bad++;
      $display("FAIL rst_dout got %h want 00", bus.io_dout); end
    n_cmp++; if (bus.io_sel !== 1'b0) begin n_bad++;
      $display("FAIL rst_sel got %b want 0", bus.io_sel); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_bad++;
      $display("FAIL rst_txv got %b want 0", bus.tx_valid); end
    n_cmp++; if (bus.io_buffer_full !== 1'b0) begin n_bad++;
      $display("FAIL rst_full got %b want 0", bus.io_buffer_full); end
    n_cmp++; if (bus.program_finish !== 1'b0) begin n_bad++;
      $display("FAIL rst_fin got %b want 0", bus.program_finish); end
    n_cmp++; if (bus.rx_ready !== 1'b1) begin n_bad++;
      $display("FAIL rst_rxr got %b want 1", bus.rx_ready); end
    step();
  endtask

  task automatic test_tx_abc();
    byte unsigned want[3] = '{8'h41, 8'h42, 8'h43};
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_wr(18'h30000, want[i]); else idle();
      step();
      if (i < 3) begin
        n_cmp++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== want[i]) begin
          n_bad++;
          $display("FAIL abc_%0d got v=%b d=%h want v=1 d=%h",
                   i, bus.tx_valid, bus.tx_data, want[i]);
        end
      end else begin
        n_cmp++;
        if (bus.tx_valid !== 1'b0) begin n_bad++;
          $display("FAIL abc_empty got %b want 0", bus.tx_valid); end
      end
    end
  endtask

  task automatic test_full();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_wr(18'h30000, 8'h61 + 8'(i));
      step();
      n_cmp++;
      if (bus.io_buffer_full !== (i == 5)) begin n_bad++;
        $display("FAIL full_w%0d got %b want %b",
                 i, bus.io_buffer_full, i == 5); end
    end
    idle();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (bus.tx_valid !== (q.size() != 0) ||
          (q.size() != 0 && bus.tx_data !== q[0])) begin
        n_bad++;
        $display("FAIL drain_%0d got v=%b d=%h want v=%b",
                 i, bus.tx_valid, bus.tx_data, q.size() != 0);
      end
      step();
      n_cmp++;
      if (bus.io_buffer_full !== (q.size() >= DEPTH - 2)) begin n_bad++;
        $display("FAIL drain_full%0d got %b want %b",
                 i, bus.io_buffer_full, q.size() >= DEPTH - 2); end
    end
  endtask

  task automatic test_stop();
    int k;
    bus.tx_ready = 1'b1;
    set_wr(18'h30000, 8'h00); step();
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_bad++;
      $display("FAIL zero_drop got %b want 0", bus.tx_valid); end
    bus.tx_ready = 1'b0;
    set_wr(18'h30000, 8'h58); step();
    set_wr(18'h30004, 8'h99); step();
    idle();
    n_cmp++; if (bus.tx_data !== 8'h58 || bus.program_finish !== 1'b0) begin
      n_bad++; $display("FAIL stop_x got d=%h f=%b want d=58 f=0",
                        bus.tx_data, bus.program_finish); end
    bus.tx_ready = 1'b1; step();
    n_cmp++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h00) begin
      n_bad++; $display("FAIL stop_nul got v=%b d=%h want v=1 d=00",
                        bus.tx_valid, bus.tx_data); end
    n_cmp++; if (bus.program_finish !== 1'b0) begin n_bad++;
      $display("FAIL stop_early got %b want 0", bus.program_finish); end
    k = 0;
    while (!fin && k < 10) begin step(); k++; end
    n_cmp++; if (bus.program_finish !== 1'b1 || k != 1) begin n_bad++;
      $display("FAIL stop_fin got %b after %0d want 1 after 1",
               bus.program_finish, k); end
    bus.tx_ready = 1'b0;
    set_wr(18'h30000, 8'h33); step(); idle();
    n_cmp++;
    if (bus.tx_data !== 8'h33 || bus.program_finish !== 1'b1) begin
      n_bad++; $display("FAIL post_stop got d=%h f=%b want d=33 f=1",
                        bus.tx_data, bus.program_finish); end
    bus.tx_ready = 1'b1; step();
  endtask

  task automatic test_counter();
    int unsigned c0;
    logic [7:0] want[4];
    int k = 0;
    idle();
    while (cyc_m[7:0] != 8'hFF && k < 300) begin step(); k++; end
    c0 = cyc_m;
    want[0] = c0[7:0]; want[1] = c0[15:8];
    want[2] = c0[23:16]; want[3] = c0[31:24];
    for (int i = 0; i < 4; i++) begin
      set_rd(18'h30004 + 18'(i)); step();
      n_cmp++;
      if (bus.io_sel !== 1'b1 || bus.io_dout !== want[i]) begin
        n_bad++; $display("FAIL cnt_b%0d got s=%b d=%h want s=1 d=%h",
                          i, bus.io_sel, bus.io_dout, want[i]);
      end
    end
    set_rd(18'h30008); step();
    n_cmp++; if (bus.io_dout !== 8'h00 || bus.io_sel !== 1'b1) begin
      n_bad++; $display("FAIL rd_other got d=%h s=%b want 00 1",
                        bus.io_dout, bus.io_sel); end
    set_rd(18'h30004); rdy = 1'b0; step();
    n_cmp++; if (bus.io_sel !== 1'b0) begin n_bad++;
      $display("FAIL rdy_low_sel got %b want 0", bus.io_sel); end
    rdy = 1'b1; step();
    n_cmp++; if (bus.io_dout !== exp_dout) begin n_bad++;
      $display("FAIL cnt_hold got %h want %h", bus.io_dout, exp_dout); end
    idle();
  endtask

  task automatic test_rx();
    idle();
    bus.rx_valid = 1'b1; bus.rx_data = 8'h5A; step();
    bus.rx_valid = 1'b0;
    n_cmp++; if (bus.rx_ready !== 1'b0) begin n_bad++;
      $display("FAIL rx_hold got %b want 0", bus.rx_ready); end
    set_rd(18'h30000); step();
    n_cmp++; if (bus.io_dout !== 8'h5A || bus.rx_ready !== 1'b1) begin
      n_bad++; $display("FAIL rx_read got d=%h r=%b want 5a 1",
                        bus.io_dout, bus.rx_ready); end
    step();
    n_cmp++; if (bus.io_dout !== 8'h00) begin n_bad++;
      $display("FAIL rx_empty got %h want 00", bus.io_dout); end
    bus.rx_valid = 1'b1; bus.rx_data = 8'hC3; step();
    bus.rx_valid = 1'b0;
    n_cmp++; if (bus.io_dout !== 8'h00 || bus.rx_ready !== 1'b0) begin
      n_bad++; $display("FAIL rx_race got d=%h r=%b want 00 0",
                        bus.io_dout, bus.rx_ready); end
    step();
    n_cmp++; if (bus.io_dout !== 8'hC3) begin n_bad++;
      $display("FAIL rx_race2 got %h want c3", bus.io_dout); end
    idle(); step();
  endtask

  task automatic test_wrap_reset();
    idle(); bus.tx_ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      set_wr(18'h30000, 8'h80 + 8'(i)); step();
    end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_wr(18'h30000, 8'hA0 + 8'(i)); step();
      n_cmp++;
      if (q.size() != DEPTH - 1 || bus.tx_data !== q[0] ||
          bus.io_buffer_full !== 1'b1) begin
        n_bad++; $display("FAIL wrap_%0d got d=%h f=%b want d=%h f=1",
                          i, bus.tx_data, bus.io_buffer_full, q[0]);
      end
    end
    #2 rst_n = 1'b0;
    idle(); bus.tx_ready = 1'b0; model_clear();
    #1;
    n_cmp++; if (bus.tx_valid !== 1'b0 || bus.io_buffer_full !== 1'b0) begin
      n_bad++; $display("FAIL async_rst got v=%b f=%b want 0 0",
                        bus.tx_valid, bus.io_buffer_full); end
    @(negedge clk); rst_n = 1'b1;
    set_rd(18'h30004); step();
    n_cmp++; if (bus.io_dout !== 8'h00) begin n_bad++;
      $display("FAIL cyc_restart got %h want 00", bus.io_dout); end
    step();
    n_cmp++; if (bus.io_dout !== 8'h01) begin n_bad++;
      $display("FAIL cyc_next got %h want 01", bus.io_dout); end
    idle();
  endtask

  task automatic test_random();
    logic [17:0] ra[7] = '{18'h30000, 18'h30004, 18'h30005, 18'h30006,
                           18'h30007, 18'h30008, 18'h20000};
    int r;
    for (int n = 0; n < 1500; n++) begin
      rdy = ($urandom % 8) != 0;
      bus.tx_ready = ($urandom % 3) != 0;
      bus.rx_valid = ($urandom % 4) == 0;
      bus.rx_data = 8'($urandom);
      r = $urandom % 10;
      if (r < 4 && q.size() < DEPTH) begin
        set_wr(18'h30000, ($urandom % 6 == 0) ? 8'h00 : 8'($urandom));
      end else if (r == 4 && ($urandom % 50) == 0 && q.size() < DEPTH) begin
        set_wr(18'h30004, 8'h00);
      end else if (r < 9) begin
        set_rd(ra[$urandom % 7]);
      end else begin
        idle();
        bus.rx_valid = ($urandom % 4) == 0;
      end
      step();
      n_cmp++;
      if (bus.tx_valid !== (q.size() != 0) ||
          (q.size() != 0 && bus.tx_data !== q[0]) ||
          bus.io_buffer_full !== (q.size() >= DEPTH - 2) ||
          bus.program_finish !== fin || bus.rx_ready !== !rx_has ||
          bus.io_sel !== exp_sel || bus.io_dout !== exp_dout) begin
        n_bad++;
        $display("FAIL rand_%0d got v=%b d=%h f=%b p=%b r=%b s=%b o=%h want v=%b f=%b p=%b r=%b s=%b o=%h",
                 n, bus.tx_valid, bus.tx_data, bus.io_buffer_full,
                 bus.program_finish, bus.rx_ready, bus.io_sel, bus.io_dout,
                 q.size() != 0, q.size() >= DEPTH - 2, fin, !rx_has,
                 exp_sel, exp_dout);
      end
    end
    rdy = 1'b1; idle();
  endtask

  initial begin
    rdy = 1'b1; rst_n = 1'b1; bus.tx_ready = 1'b0; idle();
    model_clear();
    test_reset();
    test_tx_abc();
    test_full();
    test_stop();
    test_counter();
    test_rx();
    test_wrap_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
